// File: rtl/bram_burst_reader.sv
// bram_burst_reader: burst read initiator for a single-port read-first BRAM that returns words on a valid/ready stream.
// Optional write port enabled by defining BRAM_RDR_WRITE_EN.
module bram_burst_reader #(
  parameter int unsigned RAM_WIDTH     = 8,
  parameter int unsigned RAM_ADDR_BITS = 10,
  parameter int unsigned LEN_BITS      = RAM_ADDR_BITS + 1
) (
  input  logic                     clock,
  input  logic                     reset,
`ifdef BRAM_RDR_WRITE_EN
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [RAM_ADDR_BITS-1:0] wr_addr,
  input  logic [RAM_WIDTH-1:0]     wr_data,
`endif
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [RAM_ADDR_BITS-1:0] cmd_addr,
  input  logic [LEN_BITS-1:0]      cmd_len,
  output logic [RAM_WIDTH-1:0]     rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic                     rd_last,
  output logic                     busy,
  output logic                     done,
  output logic                     ram_enable,
  output logic                     write_enable,
  output logic [RAM_ADDR_BITS-1:0] address,
  output logic [RAM_WIDTH-1:0]     input_data,
  input  logic [RAM_WIDTH-1:0]     output_data
);

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CNT_BITS   = 3;
  localparam int unsigned PTR_BITS   = 2;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] next_addr_q, next_addr_d, cur_addr;
  logic [LEN_BITS-1:0]      issue_left_q, issue_left_d, cur_left;
  logic                     issue, issue_last, done_d;
  logic                     cmd_fire, wr_fire, pop, push, credit_ok;

  // Read pipeline tags: p1 = request on the BRAM port, p2 = data on output_data
  logic p1_rd_q, p1_last_q, p2_rd_q, p2_last_q;

  logic [RAM_WIDTH-1:0]  data_q [FIFO_DEPTH];
  logic [RAM_WIDTH-1:0]  data_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] last_q, last_d;
  logic [CNT_BITS-1:0]   count_q, count_d;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign pop       = rd_valid && rd_ready;
  assign push      = p2_rd_q;
  assign credit_ok = (count_q + CNT_BITS'(p1_rd_q) + CNT_BITS'(p2_rd_q)) <= CNT_BITS'(3);
  assign rd_data   = data_q[0];
  assign rd_last   = last_q[0];

`ifdef BRAM_RDR_WRITE_EN
  assign wr_fire = wr_valid && wr_ready;
`else
  assign wr_fire = 1'b0;
`endif

  // Next-state, read issue and burst bookkeeping
  always_comb begin
    state_d      = state_q;
    next_addr_d  = next_addr_q;
    issue_left_d = issue_left_q;
    cur_addr     = next_addr_q;
    cur_left     = issue_left_q;
    issue        = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        cur_addr = cmd_addr;
        cur_left = cmd_len;
        if (cmd_fire) begin
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            issue   = credit_ok && !wr_fire;
            state_d = (issue && cmd_len == LEN_BITS'(1)) ? DRAIN : READ;
          end
        end
      end
      READ: begin
        issue = credit_ok && !wr_fire;
        if (issue && issue_left_q == LEN_BITS'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && rd_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if ((state_q == IDLE && cmd_fire && cmd_len != '0) || state_q == READ) begin
      next_addr_d  = cur_addr + RAM_ADDR_BITS'(issue);
      issue_left_d = cur_left - LEN_BITS'(issue);
    end
    issue_last = issue && (cur_left == LEN_BITS'(1));
  end

  // Shift-register FIFO: slot 0 is the head; tags beyond count stay cleared
  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    count_d = count_q;
    if (pop) begin
      for (int unsigned i = 0; i < FIFO_DEPTH - 1; i++) begin
        data_d[i] = data_q[i+1];
        last_d[i] = last_q[i+1] && (CNT_BITS'(i + 1) < count_q);
      end
      last_d[FIFO_DEPTH-1] = 1'b0;
      count_d = count_q - CNT_BITS'(1);
    end
    if (push) begin
      data_d[count_d[PTR_BITS-1:0]] = output_data;
      last_d[count_d[PTR_BITS-1:0]] = p2_last_q;
      count_d = count_d + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      next_addr_q  <= '0;
      issue_left_q <= '0;
      p1_rd_q      <= 1'b0;
      p1_last_q    <= 1'b0;
      p2_rd_q      <= 1'b0;
      p2_last_q    <= 1'b0;
      count_q      <= '0;
      last_q       <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) data_q[i] <= '0;
      rd_valid     <= 1'b0;
      cmd_ready    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      next_addr_q  <= next_addr_d;
      issue_left_q <= issue_left_d;
      p1_rd_q      <= issue;
      p1_last_q    <= issue_last;
      p2_rd_q      <= p1_rd_q;
      p2_last_q    <= p1_last_q;
      count_q      <= count_d;
      last_q       <= last_d;
      data_q       <= data_d;
      rd_valid     <= (count_d != '0);
      cmd_ready    <= (state_d == IDLE);
      busy         <= (state_d != IDLE);
      done         <= done_d;
    end
  end

  // BRAM port registers; address and data hold when idle
`ifdef BRAM_RDR_WRITE_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ram_enable   <= 1'b0;
      write_enable <= 1'b0;
      address      <= '0;
      input_data   <= '0;
      wr_ready     <= 1'b0;
    end else begin
      ram_enable   <= issue || wr_fire;
      write_enable <= wr_fire;
      wr_ready     <= 1'b1;
      if (wr_fire) begin
        address    <= wr_addr;
        input_data <= wr_data;
      end else if (issue) begin
        address    <= cur_addr;
      end
    end
  end
`else
  assign write_enable = 1'b0;
  assign input_data   = '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ram_enable <= 1'b0;
      address    <= '0;
    end else begin
      ram_enable <= issue;
      if (issue) address <= cur_addr;
    end
  end
`endif

endmodule

// File: tb/tb_bram_burst_reader.sv
// tb_bram_burst_reader: directed bench with a read-first BRAM model preloaded mem[i]=i[7:0].
`timescale 1ns/1ps
module tb_bram_burst_reader;

  localparam int unsigned W  = 8;
  localparam int unsigned AB = 10;
  localparam int unsigned LB = 11;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AB-1:0] cmd_addr = '0;
  logic [LB-1:0] cmd_len = '0;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic          rd_last;
  logic          busy;
  logic          done;
  logic          ram_enable;
  logic          write_enable;
  logic [AB-1:0] address;
  logic [W-1:0]  input_data;
  logic [W-1:0]  output_data = '0;
`ifdef BRAM_RDR_WRITE_EN
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AB-1:0] wr_addr = 10'd6;
  logic [W-1:0]  wr_data = 8'hA5;
`endif

  bram_burst_reader dut (
    .clock(clock), .reset(reset),
`ifdef BRAM_RDR_WRITE_EN
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .busy(busy), .done(done), .ram_enable(ram_enable), .write_enable(write_enable),
    .address(address), .input_data(input_data), .output_data(output_data)
  );

  always #5 clock = ~clock;

  // Read-first single-port BRAM model
  logic [W-1:0] mem [1 << AB];
  always @(posedge clock) begin
    if (ram_enable) begin
      if (write_enable) mem[address] <= input_data;
      output_data <= mem[address];
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int           ra_addr [$];
  logic         ra_we [$];
  int           ra_cyc [$];
  logic [W-1:0] bq_data [$];
  logic         bq_last [$];
  int           bq_cyc [$];
  int           done_cyc [$];
  int           issued = 0, accepted = 0, max_out = 0;
  logic         rdy_after = 1'b0;

  // Mid-cycle monitor: records BRAM requests, stream beats and done pulses
  always @(negedge clock) begin
    if (ram_enable) begin
      ra_addr.push_back(int'(address));
      ra_we.push_back(write_enable);
      ra_cyc.push_back(cyc);
      if (!write_enable) issued = issued + 1;
    end
    if (issued - accepted > max_out) max_out = issued - accepted;
    if (rd_valid && rd_ready) begin
      bq_data.push_back(rd_data);
      bq_last.push_back(rd_last);
      bq_cyc.push_back(cyc);
      accepted = accepted + 1;
    end
    if (done) done_cyc.push_back(cyc);
  end

  int tests = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    ra_addr.delete(); ra_we.delete(); ra_cyc.delete();
    bq_data.delete(); bq_last.delete(); bq_cyc.delete(); done_cyc.delete();
    issued = 0; accepted = 0; max_out = 0;
  endtask

  task automatic run_burst(input int addr, input int len, input logic [31:0] pat,
                           input int wr_k, output int e0);
    bit seen;
    seen = 1'b0;
    clear_logs();
    @(posedge clock); #1;
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_addr  = AB'(addr);
    cmd_len   = LB'(len);
    cmd_valid = 1'b1;
    rd_ready  = pat[0];
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    e0        = cyc;
    rdy_after = cmd_ready;
    for (int k = 0; k < 300 && !seen; k++) begin
      rd_ready = pat[k % 32];
`ifdef BRAM_RDR_WRITE_EN
      wr_valid = (k == wr_k);
`endif
      @(posedge clock); #1;
      seen = (done_cyc.size() != 0);
    end
`ifdef BRAM_RDR_WRITE_EN
    wr_valid = 1'b0;
`endif
    if (!seen) check("done_timeout", 0, 1);
    rd_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic check_stream(input string tag, input int start, input int len);
    check({tag, "_count"}, bq_data.size(), len);
    for (int i = 0; i < len; i++) begin
      if (i < bq_data.size()) begin
        check($sformatf("%s_data%0d", tag, i), bq_data[i], ((start + i) % 1024) % 256);
        check($sformatf("%s_last%0d", tag, i), bq_last[i], (i == len - 1));
      end
    end
  endtask

  int e0;
  int nlast;

  initial begin
    for (int i = 0; i < (1 << AB); i++) mem[i] = W'(i);

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ram_enable", ram_enable, 0);
    reset = 1'b0;

    // T1: basic burst, latency and done timing
    run_burst(5, 4, 32'hFFFF_FFFF, -1, e0);
    check_stream("t1", 5, 4);
    check("t1_first_lat", bq_cyc[0] - e0, 2);
    check("t1_back2back", bq_cyc[3] - bq_cyc[0], 3);
    check("t1_issue_at_accept", ra_cyc[0] - e0, 0);
    check("t1_done_lat", done_cyc[0] - bq_cyc[3], 1);
    check("t1_done_count", done_cyc.size(), 1);
    check("t1_cmd_ready_busy", rdy_after, 0);
    check("t1_busy_end", busy, 0);

    // T2: address wrap from the top of memory
    run_burst(1022, 4, 32'hFFFF_FFFF, -1, e0);
    check("t2_addr_n", ra_addr.size(), 4);
    check("t2_addr0", ra_addr[0], 1022);
    check("t2_addr1", ra_addr[1], 1023);
    check("t2_addr2", ra_addr[2], 0);
    check("t2_addr3", ra_addr[3], 1);
    check_stream("t2", 1022, 4);

    // T3: backpressure, order and outstanding limit
    run_burst(100, 16, 32'h5A3C_9F00, -1, e0);
    check_stream("t3", 100, 16);
    check("t3_max_outstanding", max_out, 4);
    check("t3_reads_issued", issued, 16);

    // T4: empty burst
    run_burst(3, 0, 32'hFFFF_FFFF, -1, e0);
    check("t4_no_ram", ra_addr.size(), 0);
    check("t4_done_lat", done_cyc[0] - e0, 0);
    check("t4_done_count", done_cyc.size(), 1);
    check("t4_cmd_ready", rdy_after, 1);
    check("t4_no_beats", bq_data.size(), 0);

    // T5: async reset after the third beat of an 8-word burst
    clear_logs();
    @(posedge clock); #1;
    cmd_addr = AB'(20); cmd_len = LB'(8); cmd_valid = 1'b1; rd_ready = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 50 && bq_data.size() < 3; k++) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    #1;
    check("t5_rd_valid", rd_valid, 0);
    check("t5_rd_last", rd_last, 0);
    check("t5_rd_data", rd_data, 0);
    check("t5_busy", busy, 0);
    check("t5_ram_enable", ram_enable, 0);
    check("t5_address", address, 0);
    check("t5_cmd_ready", cmd_ready, 0);
    repeat (2) @(posedge clock);
    #1;
    check("t5_no_done", done_cyc.size(), 0);
    check("t5_beats_before", bq_data.size(), 3);
    nlast = 0;
    foreach (bq_last[i]) nlast += int'(bq_last[i]);
    check("t5_no_last", nlast, 0);
    reset = 1'b0;
    run_burst(0, 2, 32'hFFFF_FFFF, -1, e0);
    check_stream("t5_after", 0, 2);

`ifdef BRAM_RDR_WRITE_EN
    // T6: write slot inside a burst, then read back the written word
    run_burst(5, 4, 32'hFFFF_FFFF, 2, e0);
    check_stream("t6", 5, 4);
    check("t6_ops", ra_addr.size(), 5);
    check("t6_op3_addr", ra_addr[3], 6);
    check("t6_op3_we", ra_we[3], 1);
    check("t6_op4_addr", ra_addr[4], 8);
    check("t6_op4_we", ra_we[4], 0);
    check("t6_wr_ready", wr_ready, 1);
    run_burst(6, 1, 32'hFFFF_FFFF, -1, e0);
    check("t6_readback_n", bq_data.size(), 1);
    check("t6_readback", bq_data[0], 8'hA5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
